barrier_stream_tx: RTL and testbench
====================================

# barrier_stream_tx

Sequential transmitter that walks the barrier table of the selected map and delivers each non-empty barrier record, one at a time, over a valid/ready stream. It reads barrier records from a synchronous map ROM (1-cycle read latency) and feeds downstream consumers such as a sequential pixel hit-tester or a collision cache. This replaces a wide parallel barrier array with a serialized record stream. A new frame (full table walk) starts after reset, on a `start` pulse, or on any change of `map_sel`.

## Interface
- MAX_BARRIERS, 34, table entries scanned per frame (indices 0..MAX_BARRIERS-1)
- FW, 10, width of each record field (rowstart, colstart, width, length)
- IW, 7, index width; 2^IW >= MAX_BARRIERS
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- map_sel  in  1  map select (0 = map 1, 1 = map 2)
- start  in  1  request a new frame for the current map
- rom_addr  out  IW+1  {frame_map, index}; registered
- rom_data  in  4*FW  {rowstart, colstart, width, length}, MSB first; valid 1 cycle after rom_addr
- tx_valid  out  1  record on tx_* is valid
- tx_ready  in  1  consumer accepts record when tx_valid && tx_ready
- tx_index  out  IW  table index of record
- tx_rowstart, tx_colstart, tx_width, tx_length  out  FW each  record fields
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of frame
- sent_count  out  IW  records transferred in the most recent/current frame

## Operation
- States: IDLE, FETCH, WAIT, SEND, DONE.
- Triggers: `start`, a `map_sel` change (registered compare against previous value), or reset. A trigger sets `pending`. `pending` resets to 1, so a frame runs automatically after reset.
- IDLE with `pending`:
  - Latch frame_map = map_sel, index = 0, clear sent_count and `pending`.
  - Go to FETCH. busy = 1.
- FETCH:
  - rom_addr = {frame_map, index}. Go to WAIT.
- WAIT: sample rom_data.
  - Record is empty if width == 0 or length == 0.
  - Non-empty: load tx_* fields and tx_index = index, set tx_valid, go to SEND.
  - Empty: skip. If index == MAX_BARRIERS-1 go to DONE; else index++ and go to FETCH.
- SEND: hold tx_valid and all tx_* fields stable until tx_ready. On the handshake:
  - tx_valid drops the next cycle and sent_count++.
  - If index == MAX_BARRIERS-1 go to DONE; else index++ and go to FETCH.
- DONE:
  - done = 1 for exactly one cycle and busy = 0 from the next cycle.
  - Go to IDLE. If `pending` is set, the next frame starts on the following edge.
- Triggers while busy:
  - A map_sel change during a frame does not abort it. It sets `pending`; the current frame completes on the latched frame_map.
  - `start` while busy also sets `pending`, so at most one queued frame.
- sent_count holds its value after DONE until the next frame start. The counter must not wrap (max MAX_BARRIERS).

## Timing
- Reset (async, immediate): tx_valid = 0, done = 0, busy = 0, rom_addr = 0, tx_* = 0, sent_count = 0, state = IDLE, pending = 1.
- Trigger sampled at edge e:
  - FETCH after e, WAIT after e+1.
  - tx_valid high after e+2 if entry 0 is non-empty.
- Throughput with tx_ready held high: one record per 3 cycles. An empty entry costs 2 cycles.
- Frame length, all entries non-empty, tx_ready = 1: 3·MAX_BARRIERS cycles + 1 DONE cycle.
- tx_valid never deasserts without a handshake, except on reset.

## Test plan
- Reset release, map_sel = 0, map-1 ROM (34 non-empty entries, entry 0 = {210, 280, 60, 10}), tx_ready = 1:
  - First beat is index 0: rowstart 210, colstart 280, width 60, length 10, 3 edges after reset release.
  - 34 beats, indices 0..33, then a single done pulse and sent_count = 34.
- map_sel 0→1, map-2 ROM (24 non-empty entries, indices 24..33 all-zero):
  - rom_addr MSB = 1.
  - Exactly 24 beats, indices 0..23, then done and sent_count = 24.
- Backpressure: tx_ready low for 5 cycles while index 3 is presented:
  - tx_valid stays high and fields stay constant.
  - After ready, index 4 follows; no loss or duplication.
- map_sel toggles while index 10 is in SEND:
  - Frame on map 1 completes with 34 records and done.
  - A map-2 frame starts automatically on the next cycle (24 records).
- rst_n asserted mid-SEND (index 7):
  - tx_valid and busy go low immediately.
  - After release, a new frame starts at index 0.
- All-zero ROM, start pulse: no tx_valid, done after 2·MAX_BARRIERS+ cycles, sent_count = 0. A second start while busy yields exactly one extra frame.

Source files
------------

// File: rtl/barrier_stream_tx.sv
// barrier_stream_tx
// Walks the barrier table of the selected map in a synchronous ROM and sends
// every non-empty record, one per handshake, over a valid/ready stream.
// A frame runs after reset, on a start pulse, or when map_sel changes; a
// trigger that arrives mid-frame is queued (at most one) and runs afterwards.

module barrier_stream_tx #(
    parameter int MAX_BARRIERS = 34,
    parameter int FW           = 10,
    parameter int IW           = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_map_sel,
    input  logic            i_start,
    output logic [IW:0]     o_rom_addr,
    input  logic [4*FW-1:0] i_rom_data,
    output logic            o_tx_valid,
    input  logic            i_tx_ready,
    output logic [IW-1:0]   o_tx_index,
    output logic [FW-1:0]   o_tx_rowstart,
    output logic [FW-1:0]   o_tx_colstart,
    output logic [FW-1:0]   o_tx_width,
    output logic [FW-1:0]   o_tx_length,
    output logic            o_busy,
    output logic            o_done,
    output logic [IW-1:0]   o_sent_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        DONE
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_BARRIERS - 1);
    localparam logic [IW-1:0] MAX_CNT  = IW'(MAX_BARRIERS);

    state_t          r_state;
    logic            r_pending;
    logic            r_mapPrev;
    logic            r_frameMap;
    logic [IW-1:0]   r_index;
    logic [IW:0]     r_romAddr;
    logic            r_txValid;
    logic [IW-1:0]   r_txIndex;
    logic [FW-1:0]   r_txRowstart;
    logic [FW-1:0]   r_txColstart;
    logic [FW-1:0]   r_txWidth;
    logic [FW-1:0]   r_txLength;
    logic            r_busy;
    logic            r_done;
    logic [IW-1:0]   r_sentCount;

    logic [FW-1:0]   w_romRowstart;
    logic [FW-1:0]   w_romColstart;
    logic [FW-1:0]   w_romWidth;
    logic [FW-1:0]   w_romLength;
    logic            w_recEmpty;
    logic            w_trigger;
    logic            w_lastIdx;
    logic [IW-1:0]   w_nextIndex;

    assign w_romRowstart = i_rom_data[4*FW-1:3*FW];
    assign w_romColstart = i_rom_data[3*FW-1:2*FW];
    assign w_romWidth    = i_rom_data[2*FW-1:FW];
    assign w_romLength   = i_rom_data[FW-1:0];
    assign w_recEmpty    = (w_romWidth == '0) || (w_romLength == '0);
    assign w_trigger     = i_start || (i_map_sel != r_mapPrev);
    assign w_lastIdx     = (r_index == LAST_IDX);
    assign w_nextIndex   = r_index + IW'(1);

    // Remember the previous map select so a change can be seen as a trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mapPrev <= 1'b0;
        end else begin
            r_mapPrev <= i_map_sel;
        end
    end

    // Frame sequencer: fetch, wait for ROM data, then send or skip each entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pending    <= 1'b1;
            r_frameMap   <= 1'b0;
            r_index      <= '0;
            r_romAddr    <= '0;
            r_txValid    <= 1'b0;
            r_txIndex    <= '0;
            r_txRowstart <= '0;
            r_txColstart <= '0;
            r_txWidth    <= '0;
            r_txLength   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sentCount  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_trigger) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (r_pending || w_trigger) begin
                        r_frameMap  <= i_map_sel;
                        r_index     <= '0;
                        r_romAddr   <= {i_map_sel, {IW{1'b0}}};
                        r_sentCount <= '0;
                        r_pending   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!w_recEmpty) begin
                        r_txValid    <= 1'b1;
                        r_txIndex    <= r_index;
                        r_txRowstart <= w_romRowstart;
                        r_txColstart <= w_romColstart;
                        r_txWidth    <= w_romWidth;
                        r_txLength   <= w_romLength;
                        r_state      <= SEND;
                    end else if (w_lastIdx) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_index   <= w_nextIndex;
                        r_romAddr <= {r_frameMap, w_nextIndex};
                        r_state   <= FETCH;
                    end
                end
                SEND: begin
                    if (i_tx_ready) begin
                        r_txValid <= 1'b0;
                        if (r_sentCount != MAX_CNT) begin
                            r_sentCount <= r_sentCount + IW'(1);
                        end
                        if (w_lastIdx) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_index   <= w_nextIndex;
                            r_romAddr <= {r_frameMap, w_nextIndex};
                            r_state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr    = r_romAddr;
    assign o_tx_valid    = r_txValid;
    assign o_tx_index    = r_txIndex;
    assign o_tx_rowstart = r_txRowstart;
    assign o_tx_colstart = r_txColstart;
    assign o_tx_width    = r_txWidth;
    assign o_tx_length   = r_txLength;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_sent_count  = r_sentCount;

endmodule

// File: tb/tb_barrier_stream_tx.sv
// Bench for barrier_stream_tx: a ROM model, directed frames, and a scoreboard
// of expected records / frame counts drained by an independent monitor.

module tb_barrier_stream_tx;

    localparam int MAXB = 34;
    localparam int FW   = 10;
    localparam int IW   = 7;

    typedef logic [IW+4*FW-1:0] rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mapSel = 1'b0;
    logic            startReq = 1'b0;
    logic            txReady = 1'b1;
    logic [IW:0]     romAddr;
    logic [4*FW-1:0] romData = '0;
    logic            txValid;
    logic [IW-1:0]   txIndex;
    logic [FW-1:0]   txRowstart;
    logic [FW-1:0]   txColstart;
    logic [FW-1:0]   txWidth;
    logic [FW-1:0]   txLength;
    logic            busy;
    logic            done;
    logic [IW-1:0]   sentCount;

    rec_t        sbQ[$];
    int          doneQ[$];
    int          tests = 0;
    int          failures = 0;
    int          doneSeen = 0;
    int unsigned cyc = 0;
    bit          romZero = 1'b0;
    bit          prevStall = 1'b0;
    bit          prevDone = 1'b0;
    rec_t        prevRec = '0;

    barrier_stream_tx #(
        .MAX_BARRIERS(MAXB),
        .FW(FW),
        .IW(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_map_sel(mapSel),
        .i_start(startReq),
        .o_rom_addr(romAddr),
        .i_rom_data(romData),
        .o_tx_valid(txValid),
        .i_tx_ready(txReady),
        .o_tx_index(txIndex),
        .o_tx_rowstart(txRowstart),
        .o_tx_colstart(txColstart),
        .o_tx_width(txWidth),
        .o_tx_length(txLength),
        .o_busy(busy),
        .o_done(done),
        .o_sent_count(sentCount)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure frame latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Map 1: every entry non-empty, entry 0 = {210,280,60,10}.
    // Map 2: entries 0..23 non-empty, 24..33 all zero.
    function automatic logic [4*FW-1:0] romWord(input logic m, input int i);
        if (!m) begin
            return {FW'(210 + i), FW'(280 + i), FW'(60 + i), FW'(10 + i)};
        end else if (i < 24) begin
            return {FW'(100 + i), FW'(300 + i), FW'(20 + i), FW'(1 + i)};
        end
        return '0;
    endfunction

    // Synchronous map ROM with one cycle of read latency.
    always @(posedge clk) begin
        romData <= romZero ? '0 : romWord(romAddr[IW], int'(romAddr[IW-1:0]));
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Queue the records a frame on map m must deliver, plus its final count.
    task automatic pushFrame(input logic m);
        logic [4*FW-1:0] w;
        int n;
        n = m ? 24 : 34;
        for (int i = 0; i < n; i++) begin
            w = romWord(m, i);
            sbQ.push_back({IW'(i), w});
        end
        doneQ.push_back(n);
    endtask

    task automatic applyStimulus();
        startReq = 1'b1;
        @(posedge clk);
        #1 startReq = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        bit found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(posedge clk);
            #1;
            if (done) found = 1'b1;
        end
        if (!found) timeoutFail(name);
    endtask

    task automatic waitIndex(input string name, input int idx, input int budget);
        bit found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(posedge clk);
            #1;
            if (txValid && (int'(txIndex) == idx)) found = 1'b1;
        end
        if (!found) timeoutFail(name);
    endtask

    // Monitor: drains the scoreboard on every handshake and every done pulse,
    // and checks that a stalled record is held stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall = 1'b0;
            prevDone  = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall valid held", txValid, 1'b1);
                checkOutput("stall fields held",
                            {txIndex, txRowstart, txColstart, txWidth, txLength}, prevRec);
            end
            if (txValid && txReady) begin
                if (sbQ.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected record: index %0d", txIndex);
                end else begin
                    checkOutput("record", {txIndex, txRowstart, txColstart, txWidth, txLength},
                                sbQ.pop_front());
                end
            end
            prevStall = txValid && !txReady;
            prevRec   = {txIndex, txRowstart, txColstart, txWidth, txLength};
            if (done) begin
                doneSeen++;
                if (prevDone) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL done width: done high two cycles in a row");
                end
                if (doneQ.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected done: sent_count %0d", sentCount);
                end else begin
                    checkOutput("sent_count at done", sentCount, IW'(doneQ.pop_front()));
                end
            end
            prevDone = done;
        end
    end

    // Directed scenario sequence.
    initial begin
        int unsigned startCyc;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset tx_valid", txValid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset rom_addr", romAddr, '0);
        checkOutput("reset sent_count", sentCount, '0);
        checkOutput("reset tx fields", {txIndex, txRowstart, txColstart, txWidth, txLength}, '0);

        // Frame 1: automatic after reset, map 1, with backpressure at index 3.
        pushFrame(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkOutput("no beat before 3 edges", txValid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("first beat valid", txValid, 1'b1);
        checkOutput("first beat index", txIndex, '0);
        checkOutput("first beat fields", {txRowstart, txColstart, txWidth, txLength},
                    {10'd210, 10'd280, 10'd60, 10'd10});
        waitIndex("reach index 3", 3, 40);
        txReady = 1'b0;
        repeat (5) @(posedge clk);
        #1 txReady = 1'b1;
        waitDone("frame 1 done", 200);

        // Frame 2: map_sel change to map 2.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sent_count held", sentCount, IW'(34));
        checkOutput("idle busy", busy, 1'b0);
        pushFrame(1'b1);
        mapSel = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("map 2 rom_addr", romAddr, 8'h80);
        checkOutput("map 2 busy", busy, 1'b1);
        waitDone("frame 2 done", 200);

        // Frames 3/4: map 1 frame, map_sel toggles while index 10 is sent.
        repeat (2) @(posedge clk);
        #1;
        pushFrame(1'b0);
        pushFrame(1'b1);
        mapSel = 1'b0;
        waitIndex("reach index 10", 10, 60);
        mapSel = 1'b1;
        waitDone("frame 3 done", 200);
        @(posedge clk);
        #1 checkOutput("gap busy low", busy, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("queued frame busy", busy, 1'b1);
        checkOutput("queued frame rom_addr", romAddr, 8'h80);
        waitDone("frame 4 done", 200);

        // Frame 5: reset asserted while index 7 is held in SEND.
        repeat (2) @(posedge clk);
        #1;
        pushFrame(1'b0);
        mapSel = 1'b0;
        waitIndex("reach index 7", 7, 60);
        txReady = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset tx_valid", txValid, 1'b0);
        checkOutput("async reset busy", busy, 1'b0);
        sbQ.delete();
        doneQ.delete();
        txReady = 1'b1;
        pushFrame(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        waitDone("frame after reset done", 200);

        // Frames 6/7: all-zero ROM, start pulses; two extra starts while busy
        // must queue only one more frame.
        repeat (2) @(posedge clk);
        #1;
        romZero = 1'b1;
        doneQ.push_back(0);
        doneQ.push_back(0);
        startCyc = cyc;
        applyStimulus();
        repeat (10) @(posedge clk);
        #1 applyStimulus();
        repeat (5) @(posedge clk);
        #1 applyStimulus();
        waitDone("zero frame 1 done", 200);
        checkOutput("zero frame latency", cyc - startCyc, 2 * MAXB + 1);
        waitDone("zero frame 2 done", 200);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("total done pulses", doneSeen, 7);
        checkOutput("records left over", sbQ.size(), 0);
        checkOutput("frames left over", doneQ.size(), 0);
        checkOutput("zero frame sent_count", sentCount, '0);
        checkOutput("final busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
